// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic phase controller: states, duration
// codes and lamp patterns.
package traffic_pkg;

    typedef enum logic [2:0] {
        ALL_RED_2   = 3'd0,
        MAIN_GREEN  = 3'd1,
        MAIN_YELLOW = 3'd2,
        ALL_RED_1   = 3'd3,
        SIDE_GREEN  = 3'd4,
        SIDE_YELLOW = 3'd5,
        PED_WALK    = 3'd6
    } tpc_state_t;

    localparam logic [1:0] SHORT  = 2'b00;
    localparam logic [1:0] MEDIUM = 2'b01;
    localparam logic [1:0] LONG   = 2'b10;

    localparam logic [1:0] DUR_GREEN  = LONG;
    localparam logic [1:0] DUR_YELLOW = SHORT;
    localparam logic [1:0] DUR_ALLRED = SHORT;
    localparam logic [1:0] DUR_WALK   = MEDIUM;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    function automatic logic [1:0] dur_of(input tpc_state_t s);
        case (s)
            MAIN_GREEN, SIDE_GREEN:   dur_of = DUR_GREEN;
            MAIN_YELLOW, SIDE_YELLOW: dur_of = DUR_YELLOW;
            PED_WALK:                 dur_of = DUR_WALK;
            default:                  dur_of = DUR_ALLRED;
        endcase
    endfunction

    // Returns {main_light, side_light}.
    function automatic logic [5:0] lamps_of(input tpc_state_t s);
        case (s)
            MAIN_GREEN:  lamps_of = {GRN, RED};
            MAIN_YELLOW: lamps_of = {YEL, RED};
            SIDE_GREEN:  lamps_of = {RED, GRN};
            SIDE_YELLOW: lamps_of = {RED, YEL};
            default:     lamps_of = {RED, RED};
        endcase
    endfunction

endpackage

// File: rtl/req_sync.sv
// Two-flop synchronizer for an asynchronous request input.
module req_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ff <= 2'b00;
        else     ff <= {ff[0], d};
    end

    assign q = ff[1];

endmodule

// File: rtl/traffic_phase_controller.sv
// Main/side road phase sequencer driving a shared duration timer.
// Define TPC_PED_EN to build the pedestrian walk phase.
module traffic_phase_controller
    import traffic_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       side_req,
    input  logic       ped_req,
    input  logic       timer_done,
    output logic       timer_start,
    output logic [1:0] duration_sel,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       ped_walk,
    output logic [2:0] phase
);

    tpc_state_t state, state_nxt;
    logic       expire;
    logic       side_sync, side_pend, side_clr;
    logic       ped_pend;

    // A still-high done from the previous phase must not count.
    assign expire = timer_done & ~timer_start;

    req_sync u_side_sync (
        .clk (clk),
        .rst (rst),
        .d   (side_req),
        .q   (side_sync)
    );

    assign side_clr = expire && (state_nxt == SIDE_GREEN);

    // Set wins over clear so a request arriving on entry is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) side_pend <= 1'b0;
        else     side_pend <= side_sync | (side_pend & ~side_clr);
    end

`ifdef TPC_PED_EN
    logic ped_sync, ped_clr;

    req_sync u_ped_sync (
        .clk (clk),
        .rst (rst),
        .d   (ped_req),
        .q   (ped_sync)
    );

    assign ped_clr = expire && (state_nxt == PED_WALK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ped_pend <= 1'b0;
            ped_walk <= 1'b0;
        end else begin
            ped_pend <= ped_sync | (ped_pend & ~ped_clr);
            ped_walk <= (state_nxt == PED_WALK);
        end
    end
`else
    logic unused_ped;

    assign unused_ped = ped_req;
    assign ped_pend   = 1'b0;
    assign ped_walk   = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        if (expire) begin
            unique case (state)
                ALL_RED_2:   state_nxt = MAIN_GREEN;
                MAIN_GREEN:  if (side_pend || ped_pend)
                                 state_nxt = MAIN_YELLOW;
                MAIN_YELLOW: state_nxt = ALL_RED_1;
                ALL_RED_1:   state_nxt = ped_pend ? PED_WALK : SIDE_GREEN;
                PED_WALK:    state_nxt = side_pend ? SIDE_GREEN : MAIN_GREEN;
                SIDE_GREEN:  state_nxt = SIDE_YELLOW;
                SIDE_YELLOW: state_nxt = ALL_RED_2;
                default:     state_nxt = ALL_RED_2;
            endcase
        end
    end

    // Every expire is a state entry, including the MAIN_GREEN re-arm.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ALL_RED_2;
            timer_start  <= 1'b1;
            duration_sel <= DUR_ALLRED;
            main_light   <= RED;
            side_light   <= RED;
        end else begin
            state       <= state_nxt;
            timer_start <= expire;
            if (expire) duration_sel <= dur_of(state_nxt);
            {main_light, side_light} <= lamps_of(state_nxt);
        end
    end

    assign phase = state;

endmodule

// File: doc/traffic_phase_controller.md
# traffic_phase_controller

Sequencing FSM for a two-road intersection (main road and side road) with an optional pedestrian phase. Each phase starts the shared duration timer with a one-cycle `timer_start` pulse and a `duration_sel` code, and advances on `timer_done`. Main road rests in green until a side-road or pedestrian request is latched. Sits between the sensor/button inputs and the lamp drivers.

## Interface
- `DUR_GREEN`, 2'b10: duration code for MAIN_GREEN and SIDE_GREEN (long).
- `DUR_YELLOW`, 2'b00: code for MAIN_YELLOW and SIDE_YELLOW (short).
- `DUR_ALLRED`, 2'b00: code for ALL_RED_1 and ALL_RED_2 (short).
- `DUR_WALK`, 2'b01: code for PED_WALK (medium).
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `side_req` in 1: side-road car sensor, level, asynchronous.
- `ped_req` in 1: pedestrian button, asynchronous.
- `timer_done` in 1: from timer; high once the selected duration has elapsed, stays high until the next start.
- `timer_start` out 1: registered one-cycle pulse that restarts the timer.
- `duration_sel` out 2: registered duration code, valid with and after `timer_start`.
- `main_light` out 3: {red, yellow, green}, one-hot.
- `side_light` out 3: {red, yellow, green}, one-hot.
- `ped_walk` out 1: walk lamp.
- `phase` out 3: current state encoding, for debug.

## Operation
- States: ALL_RED_2 (0), MAIN_GREEN (1), MAIN_YELLOW (2), ALL_RED_1 (3), SIDE_GREEN (4), SIDE_YELLOW (5), PED_WALK (6).
- Lamps per state:
  - MAIN_GREEN: main green, side red.
  - MAIN_YELLOW: main yellow, side red.
  - SIDE_GREEN: side green, main red.
  - SIDE_YELLOW: side yellow, main red.
  - All other states: both red.
  - `ped_walk` is high only in PED_WALK.
- "expire" = `timer_done`=1 while `timer_start`=0. `timer_done` is ignored whenever `timer_start` is high, because it can still be high from the previous phase.
- Transitions on expire:
  - ALL_RED_2 → MAIN_GREEN.
  - MAIN_GREEN → MAIN_YELLOW if `side_pend` or `ped_pend`; otherwise stay in MAIN_GREEN and re-pulse `timer_start`.
  - MAIN_YELLOW → ALL_RED_1.
  - ALL_RED_1 → PED_WALK if `ped_pend`, else SIDE_GREEN.
  - PED_WALK → SIDE_GREEN if `side_pend`, else MAIN_GREEN.
  - SIDE_GREEN → SIDE_YELLOW.
  - SIDE_YELLOW → ALL_RED_2.
- Every state entry, including a MAIN_GREEN re-arm, registers `timer_start`=1 and the state's code on `duration_sel` at the same edge.
- Pending latches:
  - `side_pend` is set by synchronized `side_req`=1 and cleared on entry to SIDE_GREEN.
  - `ped_pend` is set by synchronized `ped_req`=1 and cleared on entry to PED_WALK.
  - If set and clear coincide, set wins: the request stays pending for a later cycle.
- Requests are ignored only in the sense that they cannot shorten a running phase.

## Timing
- Reset values:
  - state ALL_RED_2, `phase`=0.
  - `main_light`=`side_light`=3'b100.
  - `ped_walk`=0.
  - `timer_start`=1, `duration_sel`=`DUR_ALLRED`, so the timer is armed in the first cycle after reset.
  - `side_pend`=`ped_pend`=0, synchronizer flops 0.
- Lamps and `phase` are registered and change at the same edge as the state.
- Request latency: 2-flop synchronizer plus latch, so `*_pend` is high 3 edges after the input rises.
- Phase dwell with the team timer at duration T cycles: entry edge E0 → start sampled at E1 → `timer_done` set at E(T+2) → next state at E(T+3). Dwell = T+3 cycles: short 53, medium 153, long 303.
- Reset asserted mid-phase: all outputs return to reset values immediately (asynchronous); pending requests are lost.

## Configuration
- `TPC_PED_EN` defined:
  - `ped_req` path, `ped_pend` and the PED_WALK state are present.
  - The ALL_RED_1 → PED_WALK branch is active.
- `TPC_PED_EN` undefined:
  - No `ped_pend`; `ped_req` is unconnected internally and `ped_walk` is tied 0.
  - PED_WALK is unreachable; ALL_RED_1 always goes to SIDE_GREEN.
  - MAIN_GREEN exits only on `side_pend`.

## Structure
- Package `traffic_pkg`:
  - State encoding constants.
  - Duration code constants SHORT=2'b00, MEDIUM=2'b01, LONG=2'b10.
  - Lamp encodings RED=3'b100, YEL=3'b010, GRN=3'b001.
- Sub-module `req_sync`: 2-flop synchronizer with asynchronous reset, instantiated once per request input.

## Test plan
- Reset release, no requests: `timer_start` high in cycle 1 with sel=00; MAIN_GREEN entered 53 cycles later; MAIN_GREEN re-arms every 303 cycles and lamps never change.
- `side_req` pulse during MAIN_GREEN: on expire, sequence runs MAIN_YELLOW (53), ALL_RED_1 (53), SIDE_GREEN (303), SIDE_YELLOW (53), ALL_RED_2 (53), MAIN_GREEN. Main and side are never green at the same time.
- Stale `timer_done`: hold `timer_done` high externally across a state entry; no transition occurs in the `timer_start` cycle.
- `side_req` held high continuously: a new side cycle follows each MAIN_GREEN expiry, because set wins on the SIDE_GREEN entry edge.
- `TPC_PED_EN`, `ped_req` and `side_req` both pulsed: ALL_RED_1 → PED_WALK (`ped_walk`=1, sel=01, 153 cycles) → SIDE_GREEN. Without the macro the same stimulus skips PED_WALK.
- Assert `rst` mid SIDE_GREEN: lamps go immediately to 3'b100/3'b100 and `timer_start`=1; pending requests are cleared.
